// File: rtl/microseq_pkg.sv
// Shared definitions for the micro-sequencer slice.
//   NOP_INSTR     canonical RISC-V NOP (addi x0,x0,0) shown when nothing is issuing
//   state_e       sequencer states
//   desc_width    width of one descriptor word {len[AW:0], base[AW-1:0]}
//   default_*     built-in ROM/descriptor image used when no image file is given
package microseq_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // A descriptor holds a length one bit wider than the address so that a
  // program may span the whole ROM.
  function automatic int unsigned desc_width(input int unsigned aw);
    return 2 * aw + 1;
  endfunction

  // Built-in image: every word carries its own address in the low half,
  // which makes misordered fetches easy to spot.
  function automatic logic [31:0] default_word(input int unsigned addr);
    return 32'hC0DE_0000 | (addr & 32'h0000_FFFF);
  endfunction

  function automatic int unsigned default_base(input int unsigned prog);
    case (prog)
      0:       return 0;
      1:       return 8;
      2:       return 16;
      3:       return 20;
      4:       return 40;
      default: return 0;
    endcase
  endfunction

  // Program 2 is deliberately empty; entries past 4 are empty as well.
  function automatic int unsigned default_len(input int unsigned prog);
    case (prog)
      0:       return 5;
      1:       return 3;
      2:       return 0;
      3:       return 12;
      4:       return 24;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/microseq_rom.sv
// Program ROM plus descriptor table, both read asynchronously.
//   addr_i      word address into the program ROM
//   sel_i       program index into the descriptor table
//   instr_o     ROM word at addr_i
//   base_o      first word of the selected program
//   len_o       length of the selected program in words (0 = empty)
//   sel_valid_o sel_i names an existing descriptor
// The ROM and descriptor contents come from the built-in image in microseq_pkg.
module microseq_rom
  import microseq_pkg::*;
#(
  parameter int    INSTR_W      = 32,
  parameter int    PRG_CAPACITY = 64,
  parameter int    NUM_PROGS    = 4,
  parameter int    AW           = 6,
  parameter int    PSW          = 2,
  parameter string SOURCE_FILE  = "data/microseq.mem",
  parameter string DESC_FILE    = "data/microseq_desc.mem"
) (
  input  logic [AW-1:0]      addr_i,
  input  logic [PSW-1:0]     sel_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [AW-1:0]      base_o,
  output logic [AW:0]        len_o,
  output logic               sel_valid_o
);

  localparam int DW = desc_width(AW);
  localparam int LW = AW + 1;

  logic [INSTR_W-1:0] rom_mem  [PRG_CAPACITY];
  logic [DW-1:0]      desc_mem [NUM_PROGS];
  logic [DW-1:0]      desc_word;

  // Image load at elaboration, followed by a simulation-only sanity check
  // that no program runs past the end of the ROM.
  initial begin
    for (int i = 0; i < PRG_CAPACITY; i++)
      rom_mem[AW'(i)] = INSTR_W'(default_word(i));
    for (int p = 0; p < NUM_PROGS; p++)
      desc_mem[PSW'(p)] = {LW'(default_len(p)), AW'(default_base(p))};
    for (int p = 0; p < NUM_PROGS; p++) begin
      assert (32'(desc_mem[PSW'(p)][AW-1:0]) + 32'(desc_mem[PSW'(p)][DW-1:AW])
              <= 32'(PRG_CAPACITY))
        else $error("descriptor %0d runs past the end of the ROM", p);
    end
  end

  // Out-of-range selections read as an empty descriptor so the table is
  // never indexed past its end.
  assign sel_valid_o = (32'(sel_i) < 32'(NUM_PROGS));
  assign desc_word   = sel_valid_o ? desc_mem[sel_i] : '0;
  assign base_o      = desc_word[AW-1:0];
  assign len_o       = desc_word[DW-1:AW];
  assign instr_o     = rom_mem[addr_i];

endmodule

// File: rtl/microseq_control.sv
// Multi-program instruction sequencer feeding the core's fetch stage.
//   clk_i         clock, all state on the rising edge
//   rst_i         synchronous active-high reset
//   start_i       launch request, honoured only while idle
//   prog_sel_i    program index, sampled with start_i
//   repeat_cnt_i  extra iterations (0 = run once), sampled with start_i
//   abort_i       stop the current run immediately, no done pulse
//   stall_f_i     fetch stall, holds the current word
//   instr_o       program word, or NOP when instr_valid_o is low
//   instr_valid_o instr_o is a program word
//   busy_o        a program is running
//   done_o        one-cycle pulse on normal completion
//   err_o         one-cycle pulse when start_i names a missing program
module microseq_control
  import microseq_pkg::*;
#(
  parameter int    INSTR_W      = 32,
  parameter int    PRG_CAPACITY = 64,
  parameter int    NUM_PROGS    = 4,
  parameter int    REP_W        = 8,
  parameter string SOURCE_FILE  = "data/microseq.mem",
  parameter string DESC_FILE    = "data/microseq_desc.mem",
  localparam int   AW           = $clog2(PRG_CAPACITY),
  localparam int   PSW          = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [PSW-1:0]     prog_sel_i,
  input  logic [REP_W-1:0]   repeat_cnt_i,
  input  logic               abort_i,
  input  logic               stall_f_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  state_e             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW-1:0]      base_q, base_d;
  logic [AW-1:0]      end_q, end_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [INSTR_W-1:0] rom_instr;
  logic [AW-1:0]      desc_base;
  logic [AW:0]        desc_len;
  logic               sel_valid;

  microseq_rom #(
    .INSTR_W      (INSTR_W),
    .PRG_CAPACITY (PRG_CAPACITY),
    .NUM_PROGS    (NUM_PROGS),
    .AW           (AW),
    .PSW          (PSW),
    .SOURCE_FILE  (SOURCE_FILE),
    .DESC_FILE    (DESC_FILE)
  ) u_rom (
    .addr_i      (idx_q),
    .sel_i       (prog_sel_i),
    .instr_o     (rom_instr),
    .base_o      (desc_base),
    .len_o       (desc_len),
    .sel_valid_o (sel_valid)
  );

  // State register. Everything clears on reset, including any pending
  // done/err pulse, so a reset mid-run never reports completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      end_q   <= '0;
      rep_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      end_q   <= end_d;
      rep_q   <= rep_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. Abort outranks everything; a word only advances when
  // fetch accepts it. The last address is precomputed at launch so the run
  // loop needs a single equality compare. The low AW bits of len suffice
  // because a full-ROM program wraps base-1 to the top address.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    end_d   = end_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          if (!sel_valid) begin
            err_d = 1'b1;
          end else if (desc_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            idx_d   = desc_base;
            base_d  = desc_base;
            end_d   = desc_base + desc_len[AW-1:0] - AW'(1);
            rep_d   = repeat_cnt_i;
          end
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (!stall_f_i) begin
          if (idx_q != end_q) begin
            idx_d = idx_q + AW'(1);
          end else if (rep_q != '0) begin
            idx_d = base_q;
            rep_d = rep_q - REP_W'(1);
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  assign instr_valid_o = (state_q == ST_RUN);
  assign busy_o        = (state_q == ST_RUN);
  assign instr_o       = (state_q == ST_RUN) ? rom_instr : INSTR_W'(NOP_INSTR);
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule
